// File: rtl/bus_mux_arb_pkg.sv
// Shared defaults, owner-width helper and source-index names for the
// fixed-priority bus multiplexer.
package bus_mux_arb_pkg;

    localparam int DEF_N_SRC  = 9;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_CNT_W  = 8;

    // Index of each bus source; a lower index wins when several drive at once.
    localparam int SRC_A     = 0;
    localparam int SRC_T     = 1;
    localparam int SRC_B     = 2;
    localparam int SRC_C     = 3;
    localparam int SRC_RAM   = 4;
    localparam int SRC_STACK = 5;
    localparam int SRC_MDR   = 6;
    localparam int SRC_ALU   = 7;
    localparam int SRC_PC    = 8;

    function automatic int own_w(input int n_src);
        return (n_src > 2) ? $clog2(n_src) : 1;
    endfunction

endpackage

// File: rtl/bus_prio_enc.sv
// Combinational priority encoder: picks the lowest-index requesting source
// and flags the idle and multi-driver conditions.
module bus_prio_enc
    import bus_mux_arb_pkg::*;
#(
    parameter  int N_SRC = DEF_N_SRC,
    localparam int OWN_W = own_w(N_SRC)
) (
    input  logic [N_SRC-1:0] i_src_out,
    output logic [OWN_W-1:0] o_winner,
    output logic             o_idle,
    output logic             o_contention
);

    // Scanning from the top down lets the lowest set bit overwrite the winner last.
    always_comb begin
        o_winner = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (i_src_out[k]) o_winner = OWN_W'(k);
        end
    end

    assign o_idle       = ~|i_src_out;
    assign o_contention = |(i_src_out & (i_src_out - N_SRC'(1)));

endmodule

// File: rtl/bus_mux_arb.sv
// Shared-bus multiplexer with fixed-priority arbitration, registered bus
// copy and owner, and a sticky contention error record.
module bus_mux_arb
    import bus_mux_arb_pkg::*;
#(
    parameter  int N_SRC     = DEF_N_SRC,
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int KEEP_MODE = 0,
    parameter  int CNT_W     = DEF_CNT_W,
    localparam int OWN_W     = own_w(N_SRC)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_SRC-1:0]        i_src_out,
    input  logic [N_SRC*DATA_W-1:0] i_src_data,
    input  logic                    i_err_clr,
    output logic [DATA_W-1:0]       o_bus_out,
    output logic [DATA_W-1:0]       o_bus_q,
    output logic [OWN_W-1:0]        o_owner,
    output logic                    o_idle,
    output logic                    o_contention,
    output logic                    o_err_sticky,
    output logic [CNT_W-1:0]        o_err_cnt,
    output logic [N_SRC-1:0]        o_err_mask
);

    logic [OWN_W-1:0]  winner;
    logic [DATA_W-1:0] bus_sel;

    bus_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
        .i_src_out   (i_src_out),
        .o_winner    (winner),
        .o_idle      (o_idle),
        .o_contention(o_contention)
    );

    // Only the winner's slice reaches the bus, so undriven sources may hold anything.
    always_comb begin
        bus_sel = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (!o_idle && winner == OWN_W'(k)) bus_sel = i_src_data[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        if (!o_idle)             o_bus_out = bus_sel;
        else if (KEEP_MODE != 0) o_bus_out = o_bus_q;
        else                     o_bus_out = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_bus_q <= '0;
            o_owner <= '0;
        end else begin
            o_bus_q <= o_bus_out;
            if (!o_idle) o_owner <= winner;
        end
    end

    // A clear coinciding with contention restarts the record from this cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err_sticky <= 1'b0;
            o_err_cnt    <= '0;
            o_err_mask   <= '0;
        end else if (o_contention) begin
            o_err_sticky <= 1'b1;
            if (i_err_clr || !o_err_sticky) o_err_mask <= i_src_out;
            if (i_err_clr)                  o_err_cnt  <= CNT_W'(1);
            else if (!(&o_err_cnt))         o_err_cnt  <= o_err_cnt + CNT_W'(1);
        end else if (i_err_clr) begin
            o_err_sticky <= 1'b0;
            o_err_cnt    <= '0;
            o_err_mask   <= '0;
        end
    end

endmodule

// File: tb/tb_bus_mux_arb.sv
// Directed testbench for bus_mux_arb: default and hold-mode instances on a
// shared stimulus, plus narrow and wide instances for the source walk.
module tb_bus_mux_arb;

    logic         clk;
    logic         rst_n;
    logic [8:0]   src9;
    logic [143:0] data9;
    logic         err_clr;

    logic [15:0] b0_bus_out, b0_bus_q, k1_bus_out, k1_bus_q;
    logic [3:0]  b0_owner, k1_owner;
    logic        b0_idle, b0_cont, b0_sticky, k1_idle, k1_cont, k1_sticky;
    logic [7:0]  b0_cnt, k1_cnt;
    logic [8:0]  b0_mask, k1_mask;

    logic [1:0]  src2;
    logic [15:0] data2;
    logic [7:0]  s2_bus_out, s2_bus_q, s2_cnt;
    logic [0:0]  s2_owner;
    logic        s2_idle, s2_cont, s2_sticky;
    logic [1:0]  s2_mask;

    logic [15:0]  src16;
    logic [127:0] data16;
    logic [7:0]   s16_bus_out, s16_bus_q, s16_cnt;
    logic [3:0]   s16_owner;
    logic         s16_idle, s16_cont, s16_sticky;
    logic [15:0]  s16_mask;

    int passed = 0;
    int total  = 0;

    bus_mux_arb #(.N_SRC(9), .DATA_W(16), .KEEP_MODE(0), .CNT_W(8)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_src_out(src9), .i_src_data(data9), .i_err_clr(err_clr),
        .o_bus_out(b0_bus_out), .o_bus_q(b0_bus_q), .o_owner(b0_owner), .o_idle(b0_idle),
        .o_contention(b0_cont), .o_err_sticky(b0_sticky), .o_err_cnt(b0_cnt), .o_err_mask(b0_mask)
    );

    bus_mux_arb #(.N_SRC(9), .DATA_W(16), .KEEP_MODE(1), .CNT_W(8)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_src_out(src9), .i_src_data(data9), .i_err_clr(err_clr),
        .o_bus_out(k1_bus_out), .o_bus_q(k1_bus_q), .o_owner(k1_owner), .o_idle(k1_idle),
        .o_contention(k1_cont), .o_err_sticky(k1_sticky), .o_err_cnt(k1_cnt), .o_err_mask(k1_mask)
    );

    bus_mux_arb #(.N_SRC(2), .DATA_W(8), .KEEP_MODE(0), .CNT_W(8)) dut_s2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_src_out(src2), .i_src_data(data2), .i_err_clr(err_clr),
        .o_bus_out(s2_bus_out), .o_bus_q(s2_bus_q), .o_owner(s2_owner), .o_idle(s2_idle),
        .o_contention(s2_cont), .o_err_sticky(s2_sticky), .o_err_cnt(s2_cnt), .o_err_mask(s2_mask)
    );

    bus_mux_arb #(.N_SRC(16), .DATA_W(8), .KEEP_MODE(0), .CNT_W(8)) dut_s16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_src_out(src16), .i_src_data(data16), .i_err_clr(err_clr),
        .o_bus_out(s16_bus_out), .o_bus_q(s16_bus_q), .o_owner(s16_owner), .o_idle(s16_idle),
        .o_contention(s16_cont), .o_err_sticky(s16_sticky), .o_err_cnt(s16_cnt), .o_err_mask(s16_mask)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [8:0] src, input logic clr);
        src9    = src;
        err_clr = clr;
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        src9    = '0;
        data9   = 'x;
        err_clr = 1'b0;
        src2    = '0;
        data2   = 'x;
        src16   = '0;
        data16  = 'x;

        #12;
        checkOutput("rst_bus_q",  b0_bus_q,   0);
        checkOutput("rst_owner",  b0_owner,   0);
        checkOutput("rst_sticky", b0_sticky,  0);
        checkOutput("rst_cnt",    b0_cnt,     0);
        checkOutput("rst_mask",   b0_mask,    0);
        checkOutput("rst_idle",   b0_idle,    1);
        checkOutput("rst_bus_k1", k1_bus_out, 0);
        rst_n = 1'b1;

        data9[2*16 +: 16] = 16'h1234;
        applyStimulus(9'h004, 1'b0);
        #1;
        checkOutput("single_bus_out", b0_bus_out, 16'h1234);
        checkOutput("single_cont",    b0_cont,    0);
        stepClk();
        checkOutput("single_bus_q",  b0_bus_q,  16'h1234);
        checkOutput("single_owner",  b0_owner,  2);
        checkOutput("single_cnt",    b0_cnt,    0);
        checkOutput("single_sticky", b0_sticky, 0);

        data9[0 +: 16] = 16'h00AA;
        applyStimulus(9'h005, 1'b0);
        #1;
        checkOutput("cont_bus_out", b0_bus_out, 16'h00AA);
        checkOutput("cont_flag",    b0_cont,    1);
        stepClk();
        checkOutput("cont_sticky", b0_sticky, 1);
        checkOutput("cont_mask",   b0_mask,   9'h005);
        checkOutput("cont_cnt",    b0_cnt,    1);
        checkOutput("cont_owner",  b0_owner,  0);

        data9[4*16 +: 16] = 16'h5A5A;
        applyStimulus(9'h010, 1'b1);
        stepClk();
        checkOutput("clr_sticky", b0_sticky, 0);
        checkOutput("clr_cnt",    b0_cnt,    0);
        checkOutput("clr_mask",   b0_mask,   0);
        checkOutput("clr_owner",  b0_owner,  4);
        checkOutput("clr_bus_q",  k1_bus_q,  16'h5A5A);

        applyStimulus(9'h000, 1'b0);
        #1;
        checkOutput("idle_flag",    b0_idle,    1);
        checkOutput("idle_bus_k0",  b0_bus_out, 0);
        checkOutput("idle_bus_k1",  k1_bus_out, 16'h5A5A);
        stepClk();
        checkOutput("idle_owner_k0", b0_owner, 4);
        checkOutput("idle_owner_k1", k1_owner, 4);
        checkOutput("idle_bus_q_k0", b0_bus_q, 0);
        checkOutput("idle_bus_q_k1", k1_bus_q, 16'h5A5A);

        data9[7*16 +: 16] = 16'h0777;
        applyStimulus(9'h180, 1'b0);
        #1;
        checkOutput("sat_bus_out", b0_bus_out, 16'h0777);
        for (int i = 0; i < 300; i++) stepClk();
        checkOutput("sat_cnt",    b0_cnt,    255);
        checkOutput("sat_sticky", b0_sticky, 1);
        checkOutput("sat_mask",   b0_mask,   9'h180);
        checkOutput("sat_owner",  b0_owner,  7);

        applyStimulus(9'h003, 1'b1);
        stepClk();
        checkOutput("clrcont_cnt",    b0_cnt,    1);
        checkOutput("clrcont_sticky", b0_sticky, 1);
        checkOutput("clrcont_mask",   b0_mask,   9'h003);
        applyStimulus(9'h003, 1'b0);
        stepClk();
        checkOutput("clrcont_cnt2", b0_cnt, 2);

        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_bus_q",   b0_bus_q,   0);
        checkOutput("arst_owner",   b0_owner,   0);
        checkOutput("arst_sticky",  b0_sticky,  0);
        checkOutput("arst_cnt",     b0_cnt,     0);
        checkOutput("arst_mask",    b0_mask,    0);
        checkOutput("arst_bus_q1",  k1_bus_q,   0);
        checkOutput("arst_bus_out", b0_bus_out, 16'h00AA);
        checkOutput("arst_cont",    b0_cont,    1);
        applyStimulus(9'h000, 1'b0);
        #1;
        checkOutput("arst_idle_k1", k1_bus_out, 0);
        rst_n = 1'b1;
        stepClk();
        checkOutput("post_rst_k1", k1_bus_out, 0);
        checkOutput("post_rst_sticky", b0_sticky, 0);

        for (int k = 0; k < 9; k++) begin
            data9[k*16 +: 16] = 16'h1000 + 16'(k) * 16'h0111;
            applyStimulus(9'(1) << k, 1'b0);
            #1;
            checkOutput($sformatf("walk9_bus_%0d", k), b0_bus_out, 16'h1000 + 16'(k) * 16'h0111);
            stepClk();
            checkOutput($sformatf("walk9_owner_%0d", k), b0_owner, k);
            checkOutput($sformatf("walk9_bus_q_%0d", k), b0_bus_q, 16'h1000 + 16'(k) * 16'h0111);
        end
        checkOutput("walk9_cnt", b0_cnt, 0);
        applyStimulus(9'h000, 1'b0);

        for (int k = 0; k < 2; k++) begin
            data2 = 'x;
            data2[k*8 +: 8] = 8'hA0 + 8'(k);
            src2 = 2'(1) << k;
            #1;
            checkOutput($sformatf("walk2_bus_%0d", k), s2_bus_out, 8'hA0 + 8'(k));
            stepClk();
            checkOutput($sformatf("walk2_owner_%0d", k), s2_owner, k);
        end
        src2 = '0;

        for (int k = 0; k < 16; k++) begin
            data16 = 'x;
            data16[k*8 +: 8] = 8'h30 + 8'(k) * 8'd5;
            src16 = 16'(1) << k;
            #1;
            checkOutput($sformatf("walk16_bus_%0d", k), s16_bus_out, 8'h30 + 8'(k) * 8'd5);
            stepClk();
            checkOutput($sformatf("walk16_owner_%0d", k), s16_owner, k);
        end
        checkOutput("walk16_sticky", s16_sticky, 0);
        src16 = '0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
